// File: rtl/led_pkg.sv
// Shared FSM state type and default geometry for the LED panel scan controller.
package led_pkg;

   localparam int unsigned LED_COLS_DEF   = 32;
   localparam int unsigned LED_ROWS_DEF   = 32;
   localparam int unsigned LED_BPP_DEF    = 4;
   localparam int unsigned LED_BASE_T_DEF = 16;

   typedef enum logic [1:0] {
      IDLE,
      SHIFT,
      LATCH,
      DISPLAY
   } scan_state_t;

endpackage

// File: rtl/led_shift_seq.sv
// Column shift sequencer: walks the frame-buffer columns, registers each bit onto
// led_data and pulses led_clk one cycle after the data settles.
module led_shift_seq
   import led_pkg::*;
#(
   parameter int unsigned COLS = LED_COLS_DEF
) (
   input  logic                      clk_i,
   input  logic                      rst_i,
   input  logic                      active_i,
   input  logic                      pix_data_i,
   output logic [$clog2(COLS)-1:0]   pix_col_o,
   output logic                      led_clk_o,
   output logic                      led_data_o,
   output logic                      done_o
);

   localparam int unsigned CW = $clog2(2 * COLS + 2);
   localparam int unsigned AW = $clog2(COLS);
   localparam logic [CW-1:0] LAST = CW'(2 * COLS + 1);

   logic [CW-1:0] cnt_q, cnt_d;
   logic          led_clk_q, led_clk_d;
   logic          led_data_q, led_data_d;
   logic          last_w;

   always_comb begin
      cnt_d      = '0;
      led_clk_d  = 1'b0;
      led_data_d = led_data_q;
      last_w     = 1'b0;
      if (active_i) begin
         last_w = (cnt_q == LAST);
         cnt_d  = last_w ? '0 : cnt_q + 1'b1;
         // Even count 2c+2 raises led_clk in 2c+3; odd count 2c+1 captures column c.
         led_clk_d = ~cnt_q[0] && (cnt_q >= CW'(2));
         if (cnt_q[0] && (cnt_q < LAST)) begin
            led_data_d = pix_data_i;
         end
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         cnt_q      <= '0;
         led_clk_q  <= 1'b0;
         led_data_q <= 1'b0;
      end else begin
         cnt_q      <= cnt_d;
         led_clk_q  <= led_clk_d;
         led_data_q <= led_data_d;
      end
   end

   assign pix_col_o  = cnt_q[AW:1];
   assign led_clk_o  = led_clk_q;
   assign led_data_o = led_data_q;
   assign done_o     = last_w;

endmodule

// File: rtl/led_scan_ctrl.sv
// Row/bit-plane scan controller for a shift-register LED panel (BCM timing).
// Optional LED_SCAN_BRIGHTNESS_EN adds a brightness input that trims the on-time.
module led_scan_ctrl
   import led_pkg::*;
#(
   parameter int unsigned COLS   = LED_COLS_DEF,
   parameter int unsigned ROWS   = LED_ROWS_DEF,
   parameter int unsigned BPP    = LED_BPP_DEF,
   parameter int unsigned BASE_T = LED_BASE_T_DEF
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    enable,
   output logic [5:0]              pix_row,
   output logic [$clog2(COLS)-1:0] pix_col,
   output logic [2:0]              pix_plane,
   input  logic                    pix_data,
   output logic [5:0]              row_num,
   output logic                    led_clk,
   output logic                    led_data,
   output logic                    led_lat,
   output logic                    led_oe,
   output logic                    frame_done
`ifdef LED_SCAN_BRIGHTNESS_EN
   ,
   input  logic [7:0]              brightness
`endif
);

   localparam int unsigned TMAX = BASE_T << (BPP - 1);
   localparam int unsigned TW   = $clog2(TMAX + 1);

   scan_state_t state_q, state_d;
   logic [5:0]    row_q, row_d;
   logic [2:0]    plane_q, plane_d;
   logic [TW-1:0] disp_q, disp_d;
   logic [5:0]    row_num_q, row_num_d;
   logic          frame_done_q, frame_done_d;
   logic [TW-1:0] disp_len;
   logic          disp_last;
   logic          shift_done;
   logic          oe_on;

   led_shift_seq #(
      .COLS(COLS)
   ) u_shift (
      .clk_i      (clk),
      .rst_i      (rst),
      .active_i   (state_q == SHIFT),
      .pix_data_i (pix_data),
      .pix_col_o  (pix_col),
      .led_clk_o  (led_clk),
      .led_data_o (led_data),
      .done_o     (shift_done)
   );

   assign disp_len  = TW'(BASE_T) << plane_q;
   assign disp_last = (disp_q == disp_len - 1'b1);

`ifdef LED_SCAN_BRIGHTNESS_EN
   logic [TW+7:0] on_prod;
   assign on_prod = {8'd0, disp_len} * {{TW{1'b0}}, brightness};
   assign oe_on   = (disp_q < on_prod[TW+7:8]);
`else
   assign oe_on = 1'b1;
`endif

   always_comb begin
      state_d      = state_q;
      row_d        = row_q;
      plane_d      = plane_q;
      disp_d       = '0;
      row_num_d    = row_num_q;
      frame_done_d = 1'b0;
      case (state_q)
         IDLE: begin
            if (enable) state_d = SHIFT;
         end
         SHIFT: begin
            if (shift_done) begin
               state_d   = LATCH;
               row_num_d = row_q;
            end
         end
         LATCH: state_d = DISPLAY;
         DISPLAY: begin
            disp_d = disp_q + 1'b1;
            if (disp_last) begin
               disp_d = '0;
               if (plane_q == 3'(BPP - 1)) begin
                  plane_d = '0;
                  if (row_q == 6'(ROWS - 1)) begin
                     // enable is only consulted here, so a mid-frame drop still completes the frame.
                     row_d        = '0;
                     frame_done_d = 1'b1;
                     state_d      = enable ? SHIFT : IDLE;
                  end else begin
                     row_d   = row_q + 1'b1;
                     state_d = SHIFT;
                  end
               end else begin
                  plane_d = plane_q + 1'b1;
                  state_d = SHIFT;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= IDLE;
         row_q        <= '0;
         plane_q      <= '0;
         disp_q       <= '0;
         row_num_q    <= '0;
         frame_done_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         row_q        <= row_d;
         plane_q      <= plane_d;
         disp_q       <= disp_d;
         row_num_q    <= row_num_d;
         frame_done_q <= frame_done_d;
      end
   end

   assign pix_row    = row_q;
   assign pix_plane  = plane_q;
   assign row_num    = row_num_q;
   assign led_lat    = (state_q == LATCH);
   assign led_oe     = ~((state_q == DISPLAY) && oe_on);
   assign frame_done = frame_done_q;

endmodule

// File: tb/tb_led_scan_ctrl.sv
// Self-checking bench for led_scan_ctrl (COLS=4, ROWS=2, BPP=2, BASE_T=8).
module tb_led_scan_ctrl;

   localparam int C  = 4;
   localparam int R  = 2;
   localparam int B  = 2;
   localparam int BT = 8;
   localparam int SH = 2 * C + 2;

   logic       clk;
   logic       rst;
   logic       enable;
   logic [5:0] pix_row;
   logic [1:0] pix_col;
   logic [2:0] pix_plane;
   logic       pix_data;
   logic [5:0] row_num;
   logic       led_clk, led_data, led_lat, led_oe, frame_done;

   bit mem [R][B][C];
   int errors = 0;
   int checks = 0;
   int fd_cnt = 0;
   int cur_t  = 0;

   led_scan_ctrl #(
      .COLS(C),
      .ROWS(R),
      .BPP(B),
      .BASE_T(BT)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .enable     (enable),
      .pix_row    (pix_row),
      .pix_col    (pix_col),
      .pix_plane  (pix_plane),
      .pix_data   (pix_data),
      .row_num    (row_num),
      .led_clk    (led_clk),
      .led_data   (led_data),
      .led_lat    (led_lat),
      .led_oe     (led_oe),
      .frame_done (frame_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Synchronous frame-buffer model: one-cycle read latency.
   initial pix_data = 1'b0;
   always @(posedge clk) pix_data <= mem[int'(pix_row) % R][int'(pix_plane) % B][pix_col];

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic int seg_len(input int p);
      return SH + 1 + (BT << p);
   endfunction

   function automatic int frame_len();
      int f = 0;
      for (int p = 0; p < B; p++) f += seg_len(p);
      return f * R;
   endfunction

   // Map a cycle offset from frame start to (row, plane, offset within segment).
   function automatic void locate(input int t, output int r, output int p, output int o);
      int tt;
      bit found;
      tt = t % frame_len();
      r = 0; p = 0; o = 0; found = 0;
      for (int rr = 0; rr < R; rr++) begin
         for (int pp = 0; pp < B; pp++) begin
            if (!found) begin
               if (tt < seg_len(pp)) begin
                  r = rr; p = pp; o = tt; found = 1;
               end else begin
                  tt -= seg_len(pp);
               end
            end
         end
      end
   endfunction

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s t=%0d: got %0d expected %0d", name, cur_t, act, exp);
      end
   endtask

   task automatic check_cycle(input int t);
      int r, p, o;
      int ck;
      cur_t = t;
      locate(t, r, p, o);
      chk("pix_row", int'(pix_row), r);
      chk("pix_plane", int'(pix_plane), p);
      chk("frame_done", int'(frame_done), (t > 0 && t % frame_len() == 0) ? 1 : 0);
      if (o < SH) begin
         ck = (o >= 3 && o % 2 == 1) ? 1 : 0;
         chk("shift_oe", int'(led_oe), 1);
         chk("shift_lat", int'(led_lat), 0);
         chk("shift_clk", int'(led_clk), ck);
         if (ck == 1) chk("shift_data", int'(led_data), int'(mem[r][p][(o - 3) / 2]));
         if (o % 2 == 0 && o < 2 * C) chk("shift_col", int'(pix_col), o / 2);
      end else if (o == SH) begin
         chk("latch_lat", int'(led_lat), 1);
         chk("latch_oe", int'(led_oe), 1);
         chk("latch_clk", int'(led_clk), 0);
         chk("latch_row", int'(row_num), r);
      end else begin
         chk("disp_oe", int'(led_oe), 0);
         chk("disp_lat", int'(led_lat), 0);
         chk("disp_clk", int'(led_clk), 0);
         chk("disp_row", int'(row_num), r);
      end
   endtask

   task automatic run(input int t0, input int t_end, input int drop_t);
      for (int t = t0; t < t_end; t++) begin
         check_cycle(t);
         if (frame_done) fd_cnt++;
         if (t == drop_t) enable = 1'b0;
         @(negedge clk);
      end
   endtask

   task automatic check_idle(input int n);
      chk("end_frame_done", int'(frame_done), 1);
      chk("end_oe", int'(led_oe), 1);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         chk("idle_frame_done", int'(frame_done), 0);
         chk("idle_oe", int'(led_oe), 1);
         chk("idle_lat", int'(led_lat), 0);
         chk("idle_clk", int'(led_clk), 0);
         chk("idle_row", int'(pix_row), 0);
         chk("idle_plane", int'(pix_plane), 0);
      end
   endtask

   task automatic check_reset_outputs();
      chk("rst_oe", int'(led_oe), 1);
      chk("rst_clk", int'(led_clk), 0);
      chk("rst_data", int'(led_data), 0);
      chk("rst_lat", int'(led_lat), 0);
      chk("rst_frame_done", int'(frame_done), 0);
      chk("rst_row_num", int'(row_num), 0);
      chk("rst_pix_row", int'(pix_row), 0);
      chk("rst_pix_col", int'(pix_col), 0);
      chk("rst_pix_plane", int'(pix_plane), 0);
   endtask

   typedef struct {
      int en;
      int clk_e;
      int dat_e;
      int lat_e;
      int oe_e;
      int col_e;
   } vec_t;

   vec_t tbl [19];
   int   fl;
   int   rnd;

   initial begin
      // First segment (row 0, plane 0) with columns 1,0,1,0; -1 = not checked.
      tbl[0]  = '{1, 0, -1, 0, 1,  0};
      tbl[1]  = '{1, 0, -1, 0, 1, -1};
      tbl[2]  = '{1, 0,  1, 0, 1,  1};
      tbl[3]  = '{1, 1,  1, 0, 1, -1};
      tbl[4]  = '{1, 0,  0, 0, 1,  2};
      tbl[5]  = '{1, 1,  0, 0, 1, -1};
      tbl[6]  = '{1, 0,  1, 0, 1,  3};
      tbl[7]  = '{1, 1,  1, 0, 1, -1};
      tbl[8]  = '{1, 0,  0, 0, 1, -1};
      tbl[9]  = '{1, 1,  0, 0, 1, -1};
      tbl[10] = '{1, 0, -1, 1, 1, -1};
      for (int i = 11; i < 19; i++) tbl[i] = '{1, 0, -1, 0, 0, -1};

      fl = frame_len();
      for (int r = 0; r < R; r++)
         for (int p = 0; p < B; p++)
            for (int c = 0; c < C; c++) mem[r][p][c] = 1'($urandom);
      mem[0][0][0] = 1'b1; mem[0][0][1] = 1'b0;
      mem[0][0][2] = 1'b1; mem[0][0][3] = 1'b0;

      rst = 1'b1;
      enable = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         cur_t = -1;
         check_reset_outputs();
         enable = 1'($urandom);
      end

      rst = 1'b0;
      enable = 1'b1;
      @(negedge clk);
      for (int i = 0; i < 19; i++) begin
         cur_t = i;
         enable = tbl[i].en[0];
         chk("tbl_clk", int'(led_clk), tbl[i].clk_e);
         if (tbl[i].dat_e >= 0) chk("tbl_data", int'(led_data), tbl[i].dat_e);
         chk("tbl_lat", int'(led_lat), tbl[i].lat_e);
         chk("tbl_oe", int'(led_oe), tbl[i].oe_e);
         if (tbl[i].col_e >= 0) chk("tbl_col", int'(pix_col), tbl[i].col_e);
         if (tbl[i].lat_e == 1) chk("tbl_row_num", int'(row_num), 0);
         @(negedge clk);
      end

      fd_cnt = 0;
      run(19, 2 * fl, fl + int'($urandom_range(0, 45)));
      cur_t = 2 * fl;
      chk("frame_done_count", fd_cnt, 1);
      check_idle(5);

      for (int r = 0; r < R; r++)
         for (int p = 0; p < B; p++)
            for (int c = 0; c < C; c++) mem[r][p][c] = 1'($urandom);
      enable = 1'b1;
      @(negedge clk);
      rnd = int'($urandom_range(0, 15));
      run(0, fl + 76 + rnd, -1);
      cur_t = fl + 76 + rnd;
      chk("pre_rst_oe", int'(led_oe), 0);
      rst = 1'b1;
      #1;
      check_reset_outputs();
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         check_reset_outputs();
      end
      rst = 1'b0;
      @(negedge clk);
      run(0, fl, int'($urandom_range(0, 45)));
      cur_t = fl;
      check_idle(3);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/led_scan_ctrl.md
LED_SCAN_CTRL -- requirements
Module: led_scan_ctrl

Interface
REQ-001 Parameter COLS, default 32: LEDs shifted per row; power of two, 2..64.
REQ-002 Parameter ROWS, default 32: scan rows per frame; 2..64.
REQ-003 Parameter BPP, default 4: bit planes per pixel; 1..8.
REQ-004 Parameter BASE_T, default 16: display cycles of bit plane 0; at least 1.
REQ-005 clk  in  1  single block clock; all logic on rising edge.
REQ-006 rst  in  1  asynchronous, active-high reset.
REQ-007 enable  in  1  start or continue scanning frames.
REQ-008 pix_row  out  6  frame-buffer read row.
REQ-009 pix_col  out  clog2(COLS)  frame-buffer read column.
REQ-010 pix_plane  out  3  frame-buffer read bit plane.
REQ-011 pix_data  in  1  addressed bit, valid one cycle after the address.
REQ-012 row_num  out  6  panel row select.
REQ-013 led_clk  out  1  panel shift clock.
REQ-014 led_data  out  1  panel serial data.
REQ-015 led_lat  out  1  panel latch, active high.
REQ-016 led_oe  out  1  panel output enable, active low.
REQ-017 frame_done  out  1  one-cycle pulse at end of frame.

Function
REQ-018 FSM states: IDLE, SHIFT, LATCH, DISPLAY; IDLE->SHIFT when enable=1.
REQ-019 Sequence: for row 0..ROWS-1, for plane 0..BPP-1: SHIFT, LATCH, DISPLAY.
REQ-020 SHIFT lasts exactly 2*COLS+2 cycles; cycle 2c presents pix_col=c for c=0..COLS-1.
REQ-021 led_data registered from pix_data at end of cycle 2c+1; led_clk=1 only in cycle 2c+3; led_data stable for a full cycle before each led_clk rise.
REQ-022 led_oe=1 throughout SHIFT and LATCH; led_clk=0 outside SHIFT.
REQ-023 LATCH lasts one cycle: led_lat=1 and row_num updated to the current row in that cycle.
REQ-024 DISPLAY lasts BASE_T<<plane cycles with led_oe=0; led_oe=1 in the first following cycle.
REQ-025 After DISPLAY of plane BPP-1, row ROWS-1: frame_done=1 for one cycle; row wraps to 0.
REQ-026 At frame end: enable=1 -> SHIFT of row 0 plane 0; enable=0 -> IDLE.
REQ-027 enable deasserted mid-frame: current frame completes; no abort.
REQ-028 The display counter is wide enough for BASE_T<<(BPP-1) without wrap.

Reset
REQ-029 rst=1 forces IDLE immediately, from any state.
REQ-030 Reset values: led_oe=1; led_clk, led_data, led_lat, frame_done, row_num, pix_row, pix_col and pix_plane all 0.
REQ-031 First frame after reset release starts at row 0, plane 0.

Configuration
REQ-032 Macro LED_SCAN_BRIGHTNESS_EN adds input brightness[7:0].
REQ-033 With the macro: led_oe=0 only for the first (T*brightness)>>8 cycles of each DISPLAY, where T=BASE_T<<plane; DISPLAY length is unchanged; brightness=0 keeps led_oe=1.
REQ-034 Without the macro: no brightness port; led_oe=0 for the whole of DISPLAY.

Structure
REQ-035 Package led_pkg holds the FSM state enum and the COLS, ROWS, BPP and BASE_T defaults.
REQ-036 Sub-module led_shift_seq implements the SHIFT column counter, led_clk/led_data timing and done strobe; led_scan_ctrl holds the FSM, row/plane counters and display timer.

Verification (bench parameters: COLS=4, ROWS=2, BPP=2, BASE_T=8)
REQ-037 Hold rst=1 -> led_oe=1, all other outputs 0, and they stay so while rst=1.
REQ-038 Bit pattern 1,0,1,0 for columns 0..3 -> four led_clk pulses; led_data sampled at each rise reads 1,0,1,0; SHIFT lasts 10 cycles.
REQ-039 Planes 0 and 1 -> led_oe low for 8 and then 16 consecutive cycles; a one-cycle led_lat precedes each low period.
REQ-040 enable=1 continuously -> row_num goes 0,1,0; frame_done pulses once every 2 rows x 2 planes.
REQ-041 Drop enable during row 0 -> frame finishes, frame_done pulses, FSM enters IDLE with led_oe=1.
REQ-042 Assert rst mid-DISPLAY -> led_oe=1 before the next clk edge; after release, restart at row 0, plane 0.
